// File: rtl/interval_timer_arbiter_if.sv
// Request/grant bundle between two interval requesters and the shared timer.
// The master side drives requests and lengths; the slave side is the arbiter.
interface interval_timer_arbiter_if #(
   parameter int unsigned WIDTH = 4
);
   logic [1:0]       req;
   logic [WIDTH-1:0] len0;
   logic [WIDTH-1:0] len1;
   logic [1:0]       grant;
   logic [1:0]       done;
   logic             busy;
   logic [WIDTH-1:0] count;

   modport master (
      output req, len0, len1,
      input  grant, done, busy, count
   );

   modport slave (
      input  req, len0, len1,
      output grant, done, busy, count
   );
endinterface

// File: rtl/interval_timer_arbiter.sv
// Round-robin owner of one down-counting interval timer shared by two requesters.
// Every output is taken straight from a flop, so all outputs are registered.
module interval_timer_arbiter #(
   parameter int unsigned WIDTH = 4
) (
   input logic                   clk,
   input logic                   rst,
   interval_timer_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       grant_q, grant_d;
   logic [1:0]       done_q,  done_d;
   logic             busy_q,  busy_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             last_q,  last_d;

   logic             winner;
   logic             win_valid;

   // On a tie the requester that was not served last wins.
   always_comb begin
      winner    = 1'b0;
      win_valid = 1'b0;
      unique case (bus.req)
         2'b01:   begin winner = 1'b0;    win_valid = 1'b1; end
         2'b10:   begin winner = 1'b1;    win_valid = 1'b1; end
         2'b11:   begin winner = ~last_q; win_valid = 1'b1; end
         default: begin winner = 1'b0;    win_valid = 1'b0; end
      endcase
   end

   // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      done_d  = 2'b00;
      count_d = count_q;
      last_d  = last_q;

      unique case (state_q)
         IDLE: begin
            grant_d = 2'b00;
            count_d = '0;
            if (win_valid) begin
               state_d = RUN;
               grant_d = winner ? 2'b10 : 2'b01;
               count_d = winner ? bus.len1 : bus.len0;
               last_d  = winner;
            end
         end
         RUN: begin
            // last_q holds the current owner for the whole interval.
            if (!bus.req[last_q]) begin
               state_d = IDLE;
               grant_d = 2'b00;
               count_d = '0;
            end else if (count_q == '0) begin
               state_d        = DONE;
               grant_d        = 2'b00;
               count_d        = '0;
               done_d[last_q] = 1'b1;
            end else begin
               count_d = count_q - WIDTH'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
            grant_d = 2'b00;
            count_d = '0;
         end
         default: begin
            state_d = IDLE;
            grant_d = 2'b00;
            count_d = '0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         grant_q <= 2'b00;
         done_q  <= 2'b00;
         busy_q  <= 1'b0;
         count_q <= '0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         count_q <= count_d;
         last_q  <= last_d;
      end
   end

   assign bus.grant = grant_q;
   assign bus.done  = done_q;
   assign bus.busy  = busy_q;
   assign bus.count = count_q;

endmodule

// File: doc/interval_timer_arbiter.md
# interval_timer_arbiter

Shares one WIDTH-bit down-counting timer between two requesters. Each requester asks for a timed interval of programmable length. The block grants the timer to one requester at a time using round-robin arbitration, counts the interval down, and signals completion with a one-cycle done pulse. It sits above the lab's synchronous down-counter datapath and acts as its sequencer and owner.

## Interface
Parameters:
- WIDTH, 4, counter and interval-length width.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  2  request lines; req[i] held high by requester i until done[i] or abort.
- len0  input  WIDTH  interval length for requester 0; sampled only at grant.
- len1  input  WIDTH  interval length for requester 1; sampled only at grant.
- grant  output  2  one-hot or zero; grant[i] high while requester i owns the timer.
- done  output  2  one-cycle pulse; done[i] marks completion of requester i's interval.
- busy  output  1  high in RUN and DONE.
- count  output  WIDTH  current timer value; 0 when idle.

## Operation
- One clock domain. Reset is asynchronous and active-low on rst. Clock port is clk.
- State machine has three states: IDLE, RUN, DONE. All outputs are registered.
- Round-robin pointer `last` records the most recently granted requester. Reset value is 1, so requester 0 wins the first tie.
- **IDLE**:
  - If req == 0, stay in IDLE.
  - If exactly one req bit is high, that requester wins.
  - If both are high, the requester other than `last` wins.
  - On a win, the next state is RUN. grant is set to the winner's one-hot value, count loads len of the winner, and `last` updates to the winner.
- **RUN**:
  - If req[winner] drops, this is an abort. The next state is IDLE with grant=0 and count=0, and no done pulse.
  - Otherwise, if count == 0, the next state is DONE.
  - Otherwise, count decrements by 1.
- **DONE**:
  - Lasts exactly one cycle. done[winner]=1, grant=0, count=0.
  - The next state is always IDLE.
  - req is not arbitrated in DONE, so there is a minimum of one IDLE cycle between grants.
- **Count and length rules**:
  - count never wraps below 0. Decrement happens only when count != 0.
  - len = 0 gives a one-cycle grant.
  - len = 2^WIDTH-1 gives a 2^WIDTH-cycle grant.
- The non-winning req is ignored during RUN and DONE and is not latched. It must stay high to be arbitrated in IDLE.
- Changes to len0/len1 after grant have no effect on the current interval.
- Reset values are: state=IDLE, grant=0, done=0, busy=0, count=0, last=1. Asserting rst mid-RUN clears all of these immediately and asynchronously, with no done pulse.

## Timing
- Cycle t: IDLE samples req.
- Cycle t+1 through t+1+len: grant[i]=1. count runs len, len-1, …, 0.
- Cycle t+2+len: done[i]=1, grant=0, busy=1.
- Cycle t+3+len: IDLE. The earliest next grant is visible at t+4+len.
- Latency from the req sample to the done pulse is len+2 cycles. Grant width is len+1 cycles.
- Abort timing: if req[i] is low at the RUN edge in cycle k, then grant=0, count=0, and busy=0 from cycle k+1.
- grant and done are never high in the same cycle. At most one bit of each is high at any time.

## Test plan
- **Reset:** hold rst=0 with random req → grant=0, done=0, busy=0, count=0. Release rst, then req=2'b01, len0=3 → grant=01 for 4 cycles, count 3,2,1,0, then done=01 for exactly 1 cycle, then IDLE.
- **Tie and fairness:** req=2'b11 held continuously, len0=2, len1=1 → grants in the order 0,1,0,1. Each grant is separated by a DONE cycle and an IDLE cycle. done alternates 01/10.
- **Boundary lengths:** len0=0 → grant=01 for 1 cycle, done next cycle. len1=15 (WIDTH=4) → grant=10 for 16 cycles, count 15..0 with no wrap, then done=10.
- **Abort:** grant req0 with len0=8, drop req0 when count=5 → grant=0 and count=0 next cycle, done never pulses. A pending req1 is granted after IDLE.
- **Async reset mid-RUN:** assert rst=0 between clock edges while count=6 → outputs clear before the next edge. After release with req=11, requester 0 wins because `last` has reset to 1.
- **Length stability:** change len0 from 4 to 9 during RUN → the interval still lasts 5 cycles.
